serial_tx_framer: RTL and testbench

Upstream feeder for the two-flop serial delay/synchroniser stage. Accepts a parallel word over a valid/ready handshake and drives it onto the single-bit serial line that stage samples on its d input. Output frame format is: start bit (0), data bits LSB-first, optional even parity bit, stop bit (1). The line idles high. Each bit is held for a programmable number of clk cycles.

---
 rtl/serial_tx_framer.sv | 128 ++++++++++++
 tb/tb_serial_tx_framer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_framer.sv
// ============================================================================
// Module      : serial_tx_framer
// Description : Parallel-to-serial frame transmitter (start, LSB-first data,
//               optional even parity, stop) with valid/ready word intake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_tx_framer #(
    parameter int DATA_W    = 8,
    parameter int BIT_DIV   = 4,
    parameter int PARITY_EN = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              q,
    output logic              busy,
    output logic              done
);

    localparam int c_cnt_w = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int c_idx_w = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BIT_DIV - 1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DATA_W - 1);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
    localparam logic [2:0] c_st_parity = 3'd3;
    localparam logic [2:0] c_st_stop   = 3'd4;

    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_idx_w-1:0] r_idx;
    logic [DATA_W-1:0]  r_shift;
    logic               r_par;

    logic               w_bit_end;
    logic [DATA_W-1:0]  w_shift_nxt;

    assign w_bit_end   = (r_cnt == c_cnt_last);
    assign w_shift_nxt = r_shift >> 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            q         <= 1'b1;
            din_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (r_state != c_st_idle) begin
                r_cnt <= w_bit_end ? '0 : r_cnt + c_cnt_w'(1);
            end
            case (r_state)
                c_st_idle: begin
                    if (din_valid && din_ready) begin
                        r_shift   <= din;
                        r_par     <= ^din;
                        r_cnt     <= '0;
                        q         <= 1'b0;
                        din_ready <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= c_st_start;
                    end
                end
                c_st_start: begin
                    if (w_bit_end) begin
                        r_idx   <= '0;
                        q       <= r_shift[0];
                        r_state <= c_st_data;
                    end
                end
                c_st_data: begin
                    // q already shows the next bit on the same edge the register shifts
                    if (w_bit_end) begin
                        r_shift <= w_shift_nxt;
                        if (r_idx == c_idx_last) begin
                            r_idx <= '0;
                            if (PARITY_EN != 0) begin
                                q       <= r_par;
                                r_state <= c_st_parity;
                            end else begin
                                q       <= 1'b1;
                                r_state <= c_st_stop;
                            end
                        end else begin
                            r_idx <= r_idx + c_idx_w'(1);
                            q     <= w_shift_nxt[0];
                        end
                    end
                end
                c_st_parity: begin
                    if (w_bit_end) begin
                        q       <= 1'b1;
                        r_state <= c_st_stop;
                    end
                end
                c_st_stop: begin
                    if (w_bit_end) begin
                        q         <= 1'b1;
                        din_ready <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        r_state   <= c_st_idle;
                    end
                end
                default: begin
                    q         <= 1'b1;
                    din_ready <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= c_st_idle;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_tx_framer.sv
// ============================================================================
// Module      : tb_serial_tx_framer
// Description : Frame-level checks of serial_tx_framer in three configurations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_tx_framer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din0 = '0, din1 = '0;
    logic [3:0] din2 = '0;
    logic       dv0 = 1'b0, dv1 = 1'b0, dv2 = 1'b0;
    logic       rdy0, rdy1, rdy2, q0, q1, q2, busy0, busy1, busy2, done0, done1, done2;

    int checks = 0;
    int errors = 0;
    int cfg_dw[3] = '{8, 8, 4};
    int cfg_bd[3] = '{4, 4, 1};
    int cfg_pe[3] = '{0, 1, 0};
    logic exp_q[$];
    logic cap_q[$];

    always #5 clk = ~clk;

    serial_tx_framer #(.DATA_W(8), .BIT_DIV(4), .PARITY_EN(0)) u_dut0 (
        .clk(clk), .rst(rst), .din(din0), .din_valid(dv0), .din_ready(rdy0),
        .q(q0), .busy(busy0), .done(done0));
    serial_tx_framer #(.DATA_W(8), .BIT_DIV(4), .PARITY_EN(1)) u_dut1 (
        .clk(clk), .rst(rst), .din(din1), .din_valid(dv1), .din_ready(rdy1),
        .q(q1), .busy(busy1), .done(done1));
    serial_tx_framer #(.DATA_W(4), .BIT_DIV(1), .PARITY_EN(0)) u_dut2 (
        .clk(clk), .rst(rst), .din(din2), .din_valid(dv2), .din_ready(rdy2),
        .q(q2), .busy(busy2), .done(done2));

    function automatic logic get_q(input int sel);
        case (sel) 0: return q0; 1: return q1; default: return q2; endcase
    endfunction
    function automatic logic get_busy(input int sel);
        case (sel) 0: return busy0; 1: return busy1; default: return busy2; endcase
    endfunction
    function automatic logic get_done(input int sel);
        case (sel) 0: return done0; 1: return done1; default: return done2; endcase
    endfunction
    function automatic logic get_rdy(input int sel);
        case (sel) 0: return rdy0; 1: return rdy1; default: return rdy2; endcase
    endfunction

    task automatic drive(input int sel, input logic v, input logic [7:0] w);
        case (sel)
            0: begin dv0 = v; din0 = w; end
            1: begin dv1 = v; din1 = w; end
            default: begin dv2 = v; din2 = w[3:0]; end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference line waveform: one entry per clk cycle, counted from the accept edge.
    task automatic build_frame(input int dw, input int bd, input int pe, input logic [7:0] w);
        logic bits[$];
        int ones;
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < dw; i++) begin
            bits.push_back(w[i]);
            ones += int'(w[i]);
        end
        if (pe != 0) bits.push_back((ones % 2) != 0);
        bits.push_back(1'b1);
        exp_q.delete();
        foreach (bits[i]) repeat (bd) exp_q.push_back(bits[i]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int s = 0; s < 3; s++) drive(s, 1'b1, 8'hFF);
        for (int c = 0; c < 2; c++) begin
            tick();
            for (int s = 0; s < 3; s++) begin
                checks++;
                if (get_q(s) !== 1'b1 || get_rdy(s) !== 1'b1 || get_busy(s) !== 1'b0 || get_done(s) !== 1'b0) begin
                    errors++;
                    $display("FAIL reset dut%0d: q=%b rdy=%b busy=%b done=%b, expected q=1 rdy=1 busy=0 done=0",
                             s, get_q(s), get_rdy(s), get_busy(s), get_done(s));
                end
            end
        end
        rst = 1'b0;
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 8'h00);
        tick();
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (get_busy(s) !== 1'b0 || get_q(s) !== 1'b1) begin
                errors++;
                $display("FAIL reset_no_accept dut%0d: busy=%b q=%b, expected busy=0 q=1", s, get_busy(s), get_q(s));
            end
        end
    endtask

    task automatic test_frame(input int sel, input logic [7:0] word, input string name);
        int n;
        build_frame(cfg_dw[sel], cfg_bd[sel], cfg_pe[sel], word);
        n = exp_q.size();
        cap_q.delete();
        drive(sel, 1'b1, word);
        tick();
        drive(sel, 1'b0, ~word);
        for (int j = 0; j < n; j++) begin
            cap_q.push_back(get_q(sel));
            checks++;
            if (get_q(sel) !== exp_q[j] || get_busy(sel) !== 1'b1 || get_done(sel) !== 1'b0 || get_rdy(sel) !== 1'b0) begin
                errors++;
                $display("FAIL %s dut%0d cycle %0d: q=%b busy=%b done=%b rdy=%b, expected q=%b busy=1 done=0 rdy=0",
                         name, sel, j, get_q(sel), get_busy(sel), get_done(sel), get_rdy(sel), exp_q[j]);
            end
            tick();
        end
        checks++;
        if (get_done(sel) !== 1'b1 || get_busy(sel) !== 1'b0 || get_rdy(sel) !== 1'b1 || get_q(sel) !== 1'b1) begin
            errors++;
            $display("FAIL %s dut%0d done_edge %0d: done=%b busy=%b rdy=%b q=%b, expected done=1 busy=0 rdy=1 q=1",
                     name, sel, n, get_done(sel), get_busy(sel), get_rdy(sel), get_q(sel));
        end
        tick();
        checks++;
        if (get_done(sel) !== 1'b0 || get_busy(sel) !== 1'b0) begin
            errors++;
            $display("FAIL %s dut%0d after_done: done=%b busy=%b, expected done=0 busy=0",
                     name, sel, get_done(sel), get_busy(sel));
        end
    endtask

    task automatic test_default_a5();
        logic exp_bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        test_frame(0, 8'hA5, "a5");
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (cap_q.size() <= 4 * i + k || cap_q[4 * i + k] !== exp_bits[i]) begin
                    errors++;
                    $display("FAIL a5_bit%0d sub%0d: got %b, expected %b", i, k,
                             (cap_q.size() > 4 * i + k) ? cap_q[4 * i + k] : 1'bx, exp_bits[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 3; s++) begin
            repeat (4) test_frame(s, 8'($urandom), "random");
        end
    endtask

    task automatic test_parity();
        test_frame(1, 8'h07, "par07");
        checks++;
        if (cap_q.size() != 44 || cap_q[36] !== 1'b1) begin
            errors++;
            $display("FAIL parity_07: len=%0d bit=%b, expected len=44 bit=1", cap_q.size(),
                     (cap_q.size() > 36) ? cap_q[36] : 1'bx);
        end
        test_frame(1, 8'h03, "par03");
        checks++;
        if (cap_q.size() != 44 || cap_q[36] !== 1'b0) begin
            errors++;
            $display("FAIL parity_03: len=%0d bit=%b, expected len=44 bit=0", cap_q.size(),
                     (cap_q.size() > 36) ? cap_q[36] : 1'bx);
        end
    endtask

    task automatic test_back_to_back();
        logic tl[$];
        logic got[$];
        int n, dones, start2, gap;
        build_frame(8, 4, 0, 8'h00);
        n = exp_q.size();
        tl = exp_q;
        tl.push_back(1'b1);
        build_frame(8, 4, 0, 8'hFF);
        foreach (exp_q[i]) tl.push_back(exp_q[i]);
        tl.push_back(1'b1);
        dones = 0;
        drive(0, 1'b1, 8'h00);
        tick();
        drive(0, 1'b1, 8'hFF);
        for (int j = 0; j <= 2 * n + 1; j++) begin
            got.push_back(q0);
            if (done0 === 1'b1) dones++;
            checks++;
            if (q0 !== tl[j]) begin
                errors++;
                $display("FAIL b2b cycle %0d: q=%b, expected %b", j, q0, tl[j]);
            end
            if (j == n + 1) drive(0, 1'b0, 8'h00);
            tick();
        end
        start2 = -1;
        for (int j = n + 1; j < got.size(); j++) begin
            if (start2 < 0 && got[j] === 1'b0) start2 = j;
        end
        gap = 0;
        for (int j = n; j >= 0 && got[j] === 1'b1; j--) gap++;
        checks++;
        if (dones != 2) begin
            errors++;
            $display("FAIL b2b_dones: got %0d pulses, expected 2", dones);
        end
        checks++;
        if (start2 != n + 1) begin
            errors++;
            $display("FAIL b2b_start2: second start at edge %0d, expected %0d", start2, n + 1);
        end
        checks++;
        if (gap != 5) begin
            errors++;
            $display("FAIL b2b_gap: idle-high run %0d cycles, expected 5", gap);
        end
        tick();
    endtask

    task automatic test_midframe_abort();
        logic [7:0] word;
        int dones;
        word = 8'($urandom);
        build_frame(8, 4, 0, word);
        drive(0, 1'b1, word);
        tick();
        drive(0, 1'b0, ~word);
        for (int j = 0; j < 15; j++) begin
            checks++;
            if (q0 !== exp_q[j] || busy0 !== 1'b1) begin
                errors++;
                $display("FAIL midframe cycle %0d: q=%b busy=%b, expected q=%b busy=1", j, q0, busy0, exp_q[j]);
            end
            if (j >= 4 && j <= 9) drive(0, 1'b1, 8'($urandom));
            else drive(0, 1'b0, 8'h00);
            if (j == 14) rst = 1'b1;
            tick();
        end
        checks++;
        if (q0 !== 1'b1 || busy0 !== 1'b0 || rdy0 !== 1'b1 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL abort: q=%b busy=%b rdy=%b done=%b, expected q=1 busy=0 rdy=1 done=0", q0, busy0, rdy0, done0);
        end
        rst = 1'b0;
        dones = 0;
        for (int j = 0; j < 50; j++) begin
            tick();
            if (done0 === 1'b1 || rdy0 !== 1'b1 || q0 !== 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL abort_idle: %0d cycles with done/not-idle, expected 0", dones);
        end
    endtask

    task automatic test_bitdiv1();
        logic exp_seq[6] = '{0, 1, 0, 0, 1, 1};
        test_frame(2, 8'h09, "bd1_1001");
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (cap_q.size() != 6 || cap_q[i] !== exp_seq[i]) begin
                errors++;
                $display("FAIL bd1_seq%0d: len=%0d q=%b, expected len=6 q=%b", i, cap_q.size(),
                         (cap_q.size() > i) ? cap_q[i] : 1'bx, exp_seq[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_a5();
        test_random();
        test_parity();
        test_back_to_back();
        test_bitdiv1();
        test_midframe_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
